// File: rtl/trace_ring.sv
// trace_ring
// ----------
// Shift-register ring that holds one wall column {side, height} per screen
// column. The tracer fills it during vblank through a valid/ready write port.
// The renderer reads the head entry and rotates the ring once per visible
// pixel. Column addressing is implicit: next_column counts how many rotations
// have happened modulo COLUMNS, so it names the column currently at the head.
//
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   load_en      - write window (driven from vblank at the top level)
//   wr_valid     - tracer offers a column
//   wr_ready     - ring accepts the offered column this cycle
//   wr_column    - index of the offered column
//   wr_side      - wall side of the offered column
//   wr_height    - wall height of the offered column
//   next_column  - column index currently at the head
//   load_done    - one-cycle pulse after column COLUMNS-1 is accepted
//   wr_error     - sticky column-order violation flag
//   rd_advance   - renderer consumed the head; rotate by one
//   rd_side      - side of the head entry
//   rd_height    - height of the head entry

module trace_ring #(
    parameter int COLUMNS     = 640,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [9:0]             wr_column,
    input  logic                   wr_side,
    input  logic [HEIGHT_BITS-1:0] wr_height,
    output logic [9:0]             next_column,
    output logic                   load_done,
    output logic                   wr_error,
    input  logic                   rd_advance,
    output logic                   rd_side,
    output logic [HEIGHT_BITS-1:0] rd_height
);

    localparam int         ENTRY_BITS = HEIGHT_BITS + 1;
    localparam logic [9:0] LAST_COL   = 10'(COLUMNS - 1);

    logic [ENTRY_BITS-1:0] ring [COLUMNS];

    logic accept;
    logic write_match;
    logic write_mismatch;
    logic rotate;
    logic [ENTRY_BITS-1:0] tail_entry;

    // The read side has priority: an advance blocks the write for that cycle
    // so the tracer holds its data and retries.
    assign wr_ready       = load_en && !rd_advance;
    assign accept         = wr_valid && wr_ready;
    assign write_match    = accept && (wr_column == next_column);
    assign write_mismatch = accept && (wr_column != next_column);
    assign rotate         = rd_advance || write_match;

    // A plain advance recirculates the head; a matching write replaces it,
    // so the new data lands at the tail as the ring turns.
    assign tail_entry = rd_advance ? ring[0] : {wr_side, wr_height};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COLUMNS; i++) begin
                ring[i] <= '0;
            end
            next_column <= '0;
            load_done   <= 1'b0;
            wr_error    <= 1'b0;
        end else begin
            load_done <= write_match && (next_column == LAST_COL);
            if (write_mismatch) begin
                wr_error <= 1'b1;
            end
            if (rotate) begin
                for (int i = 0; i < COLUMNS - 1; i++) begin
                    ring[i] <= ring[i+1];
                end
                ring[COLUMNS-1] <= tail_entry;
                // Explicit compare-and-wrap keeps the counter exact for
                // non power-of-two column counts.
                if (next_column == LAST_COL) begin
                    next_column <= '0;
                end else begin
                    next_column <= next_column + 10'd1;
                end
            end
        end
    end

    // Head entry is a direct register view: zero read latency.
    assign rd_side   = ring[0][HEIGHT_BITS];
    assign rd_height = ring[0][HEIGHT_BITS-1:0];

endmodule
